// File: rtl/mips_run_pkg.sv
// Shared types and elaboration helpers for the MIPS run controller.
package mips_run_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } run_state_e;

    // Width of the hold counter: it must reach the release point of the last core
    function automatic int hold_cnt_width(input int rst_cycles, input int num_cores,
                                          input int stagger);
        return $clog2(rst_cycles + (num_cores - 1) * stagger + 1);
    endfunction

    // Legal parameter combinations for the controller
    function automatic bit params_ok(input int num_cores, input int rst_cycles,
                                     input int halt_repeat, input int max_cycles);
        return (num_cores >= 1) && (num_cores <= 8) && (rst_cycles >= 1)
            && (halt_repeat >= 2) && (max_cycles >= 1);
    endfunction

endpackage

// File: rtl/mips_run_ctrl_halt_detect.sv
// Program-completion detector: PC self-loop (repeated PC) or fixed halt address.
module mips_halt_detect
    import mips_run_pkg::*;
#(
    parameter int              PC_W        = 32,
    parameter int              HALT_REPEAT = 3,
    parameter int              HALT_PC_EN  = 0,
    parameter logic [PC_W-1:0] HALT_PC     = PC_W'(32'h0000_3000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_pc_valid,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_halt_hit
);

    localparam int              REP_W    = $clog2(HALT_REPEAT);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_REPEAT - 1);

    logic [PC_W-1:0]  r_last_pc;
    logic [REP_W-1:0] r_rep_cnt;
    logic             w_same;
    logic             w_rep_hit;
    logic             w_pc_hit;

    // rep_cnt already at HALT_REPEAT-1 plus one more matching PC completes the run
    assign w_same     = (i_pc == r_last_pc);
    assign w_rep_hit  = i_pc_valid && w_same && (r_rep_cnt >= REP_LAST);
    assign w_pc_hit   = (HALT_PC_EN != 0) && i_pc_valid && (i_pc == HALT_PC);
    assign o_halt_hit = i_en && (w_rep_hit || w_pc_hit);

    // Track the current PC run length; forget history whenever the core is not running
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_last_pc <= '0;
            r_rep_cnt <= '0;
        end else if (!i_en) begin
            r_last_pc <= '0;
            r_rep_cnt <= '0;
        end else if (i_pc_valid) begin
            if (w_same) begin
                if (r_rep_cnt != REP_LAST) r_rep_cnt <= r_rep_cnt + 1'b1;
            end else begin
                r_last_pc <= i_pc;
                r_rep_cnt <= REP_W'(1);
            end
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: staggered core reset release, cycle counting, halt and watchdog.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int              NUM_CORES   = 1,
    parameter int              PC_W        = 32,
    parameter int              CNT_W       = 32,
    parameter int              RST_CYCLES  = 4,
    parameter int              STAGGER     = 0,
    parameter int              HALT_REPEAT = 3,
    parameter int              HALT_PC_EN  = 0,
    parameter logic [PC_W-1:0] HALT_PC     = PC_W'(32'h0000_3000),
    parameter int              MAX_CYCLES  = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pc_valid,
    input  logic [PC_W-1:0]      pc,
    output logic [NUM_CORES-1:0] core_rst_n,
    output logic                 running,
    output logic                 halted,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [PC_W-1:0]      halt_pc
);

    localparam int                HOLD_W    = hold_cnt_width(RST_CYCLES, NUM_CORES, STAGGER);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES + (NUM_CORES - 1) * STAGGER);
    localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(MAX_CYCLES - 1);

    if (!params_ok(NUM_CORES, RST_CYCLES, HALT_REPEAT, MAX_CYCLES)) begin : g_bad_params
        $error("mips_run_ctrl: illegal parameter combination");
    end

    run_state_e            r_state;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [NUM_CORES-1:0]  r_core_rst_n;
    logic                  r_running;
    logic                  r_halted;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_cycle_count;
    logic [PC_W-1:0]       r_halt_pc;

    logic [HOLD_W-1:0]     w_hold_next;
    logic [NUM_CORES-1:0]  w_release;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_run;
    logic                  w_halt_hit;

    assign w_hold_next = r_hold_cnt + 1'b1;
    assign w_cnt_next  = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
    assign w_run       = (r_state == ST_RUN);

    // Per-core release strobe: core i leaves reset when the hold count hits its slot
    always_comb begin
        // NOTE: default first so every bit is assigned on every pass and no latch is inferred.
        w_release = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_release[i] = (w_hold_next == HOLD_W'(RST_CYCLES + i * STAGGER));
        end
    end

    mips_halt_detect #(
        .PC_W        (PC_W),
        .HALT_REPEAT (HALT_REPEAT),
        .HALT_PC_EN  (HALT_PC_EN),
        .HALT_PC     (HALT_PC)
    ) u_halt_detect (
        .clk        (clk),
        .rst_n      (reset),
        .i_en       (w_run),
        .i_pc_valid (pc_valid),
        .i_pc       (pc),
        .o_halt_hit (w_halt_hit)
    );

    // Sequencer FSM with all outputs registered; abort overrides every other event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_core_rst_n  <= '0;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
            r_halt_pc     <= '0;
        end else if (abort) begin
            r_state      <= ST_IDLE;
            r_core_rst_n <= '0;
            r_running    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                    if (start) begin
                        r_state       <= ST_HOLD;
                        r_hold_cnt    <= '0;
                        r_core_rst_n  <= '0;
                        r_halted      <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_cycle_count <= '0;
                        r_halt_pc     <= '0;
                    end
                end
                ST_HOLD: begin
                    r_hold_cnt   <= w_hold_next;
                    r_core_rst_n <= r_core_rst_n | w_release;
                    if (w_hold_next == HOLD_LAST) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cycle_count <= w_cnt_next;
                    if (w_halt_hit) begin
                        r_state   <= ST_HALTED;
                        r_halted  <= 1'b1;
                        r_halt_pc <= pc;
                        r_running <= 1'b0;
                    end else if (r_cycle_count == WD_LAST) begin
                        r_state   <= ST_TIMEOUT;
                        r_timeout <= 1'b1;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_core_rst_n <= '0;
                    r_running    <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_n  = r_core_rst_n;
    assign running     = r_running;
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;
    assign halt_pc     = r_halt_pc;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed scenarios plus randomized run.
module tb_mips_run_ctrl;

    localparam int          NC          = 2;
    localparam int          RST_CYCLES  = 4;
    localparam int          STAGGER     = 2;
    localparam int          HALT_REPEAT = 3;
    localparam logic [31:0] HALT_ADDR   = 32'h0000_3010;
    localparam int          MAX_CYCLES  = 10;

    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          pc_valid;
    logic [31:0]   pc;
    logic [NC-1:0] core_rst_n;
    logic          running;
    logic          halted;
    logic          timeout;
    logic [31:0]   cycle_count;
    logic [31:0]   halt_pc;

    int n_cmp = 0;
    int n_bad = 0;

    mips_run_ctrl #(
        .NUM_CORES   (NC),
        .PC_W        (32),
        .CNT_W       (32),
        .RST_CYCLES  (RST_CYCLES),
        .STAGGER     (STAGGER),
        .HALT_REPEAT (HALT_REPEAT),
        .HALT_PC_EN  (1),
        .HALT_PC     (HALT_ADDR),
        .MAX_CYCLES  (MAX_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .pc_valid    (pc_valid),
        .pc          (pc),
        .core_rst_n  (core_rst_n),
        .running     (running),
        .halted      (halted),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .halt_pc     (halt_pc)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (rule-level, not cycle-structural) ----------------
    int          m_mode;
    int          m_age;
    logic [31:0] m_cnt;
    logic [31:0] m_hpc;
    bit          m_halted, m_timeout, m_running;
    logic [NC-1:0] m_rst;
    logic [31:0] m_pcs[$];

    task automatic model_reset();
        m_mode = M_IDLE; m_age = 0; m_cnt = 0; m_hpc = 0;
        m_halted = 0; m_timeout = 0; m_running = 0; m_rst = '0;
        m_pcs.delete();
    endtask

    task automatic model_step(input bit st, input bit ab, input bit pv, input logic [31:0] p);
        bit wd, rep, hit;
        if (ab) begin
            m_mode = M_IDLE; m_running = 0; m_rst = '0;
            return;
        end
        case (m_mode)
            M_IDLE, M_DONE: if (st) begin
                m_mode = M_HOLD; m_age = 0; m_cnt = 0; m_hpc = 0;
                m_halted = 0; m_timeout = 0; m_rst = '0;
            end
            M_HOLD: begin
                m_age++;
                for (int i = 0; i < NC; i++) m_rst[i] = (m_age >= RST_CYCLES + i * STAGGER);
                if (m_age == RST_CYCLES + (NC - 1) * STAGGER) begin
                    m_mode = M_RUN; m_running = 1; m_pcs.delete();
                end
            end
            default: begin
                wd = (m_cnt == MAX_CYCLES - 1);
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                rep = 0;
                if (pv) begin
                    m_pcs.push_back(p);
                    if (m_pcs.size() >= HALT_REPEAT) begin
                        rep = 1;
                        for (int k = 0; k < HALT_REPEAT; k++)
                            if (m_pcs[m_pcs.size() - 1 - k] != p) rep = 0;
                    end
                end
                hit = pv && (rep || p == HALT_ADDR);
                if (hit) begin
                    m_mode = M_DONE; m_halted = 1; m_hpc = p; m_running = 0;
                end else if (wd) begin
                    m_mode = M_DONE; m_timeout = 1; m_running = 0;
                end
            end
        endcase
    endtask

    function automatic logic [68:0] dut_vec();
        return {core_rst_n, running, halted, timeout, cycle_count, halt_pc};
    endfunction

    function automatic logic [68:0] mdl_vec();
        return {m_rst, m_running, m_halted, m_timeout, m_cnt, m_hpc};
    endfunction

    // One clock edge with the given inputs; outputs are observed 1 time unit later
    task automatic cyc(input bit st, input bit ab, input bit pv, input logic [31:0] p);
        start = st; abort = ab; pc_valid = pv; pc = p;
        @(posedge clk);
        model_step(st, ab, pv, p);
        #1;
        start = 1'b0; abort = 1'b0;
    endtask

    // Start pulse plus the full staggered hold, ending in RUN
    task automatic run_up();
        cyc(1, 0, 0, 32'h0);
        repeat (RST_CYCLES + (NC - 1) * STAGGER) cyc(0, 0, 0, 32'h0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; start = 0; abort = 0; pc_valid = 0; pc = 0;
        model_reset();
        #12;
        n_cmp++;
        if (dut_vec() !== 69'd0) begin
            $display("FAIL reset_values: got %h want %h", dut_vec(), 69'd0); n_bad++;
        end
        reset = 1'b1;
        repeat (3) cyc(0, 0, 1, 32'h40);
        n_cmp++;
        if (dut_vec() !== 69'd0) begin
            $display("FAIL idle_no_start: got %h want %h", dut_vec(), 69'd0); n_bad++;
        end
    endtask

    task automatic test_stagger();
        logic [NC-1:0] exp_rst;
        cyc(1, 0, 0, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            cyc(0, 0, 0, 32'h0);
            exp_rst = (k < 4) ? 2'b00 : (k < 6) ? 2'b01 : 2'b11;
            n_cmp++;
            if ({core_rst_n, running} !== {exp_rst, k >= 6}) begin
                $display("FAIL stagger_edge%0d: rst/run got %b%b want %b%b",
                         k, core_rst_n, running, exp_rst, k >= 6);
                n_bad++;
            end
        end
    endtask

    task automatic test_halt_repeat();
        logic [31:0] seq [5];
        seq = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008};
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, seq[k]);
            if (k == 3) begin
                n_cmp++;
                if (halted !== 1'b0) begin
                    $display("FAIL halt_repeat_early: halted got %b want 0", halted); n_bad++;
                end
            end
        end
        n_cmp++;
        if ({halted, timeout, running, cycle_count, halt_pc} !== {3'b100, 32'd5, 32'h3008}) begin
            $display("FAIL halt_repeat: got h%b t%b r%b cnt %0d pc %h want h1 t0 r0 cnt 5 pc 3008",
                     halted, timeout, running, cycle_count, halt_pc);
            n_bad++;
        end
        repeat (2) cyc(0, 0, 1, 32'h3100);
        n_cmp++;
        if ({halted, cycle_count, core_rst_n} !== {1'b1, 32'd5, 2'b11}) begin
            $display("FAIL halt_frozen: got h%b cnt %0d rst %b want h1 cnt 5 rst 11",
                     halted, cycle_count, core_rst_n);
            n_bad++;
        end
    endtask

    task automatic test_timeout();
        run_up();
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 1, 32'h100 + 32'(4 * k));
            if (k == 9) begin
                n_cmp++;
                if ({timeout, running} !== 2'b01) begin
                    $display("FAIL timeout_early: t%b r%b want t0 r1", timeout, running); n_bad++;
                end
            end
        end
        n_cmp++;
        if ({halted, timeout, running, cycle_count} !== {3'b010, 32'd10}) begin
            $display("FAIL timeout: got h%b t%b r%b cnt %0d want h0 t1 r0 cnt 10",
                     halted, timeout, running, cycle_count);
            n_bad++;
        end
    endtask

    task automatic test_timeout_vs_halt();
        run_up();
        for (int k = 1; k <= 10; k++) cyc(0, 0, 1, (k >= 8) ? 32'h700 : 32'h600 + 32'(4 * k));
        n_cmp++;
        if ({halted, timeout, cycle_count, halt_pc} !== {2'b10, 32'd10, 32'h700}) begin
            $display("FAIL halt_beats_wd: got h%b t%b cnt %0d pc %h want h1 t0 cnt 10 pc 700",
                     halted, timeout, cycle_count, halt_pc);
            n_bad++;
        end
    endtask

    task automatic test_halt_pc();
        run_up();
        cyc(0, 0, 1, 32'h3008);
        cyc(0, 0, 1, 32'h300c);
        cyc(0, 0, 1, 32'h3010);
        n_cmp++;
        if ({halted, running, cycle_count, halt_pc} !== {2'b10, 32'd3, 32'h3010}) begin
            $display("FAIL halt_pc: got h%b r%b cnt %0d pc %h want h1 r0 cnt 3 pc 3010",
                     halted, running, cycle_count, halt_pc);
            n_bad++;
        end
    endtask

    task automatic test_valid_gaps();
        run_up();
        cyc(0, 0, 1, 32'h200);
        cyc(0, 0, 1, 32'h200);
        cyc(0, 0, 0, 32'h3010);
        cyc(0, 0, 0, 32'h200);
        n_cmp++;
        if (halted !== 1'b0) begin
            $display("FAIL gap_holds: halted got %b want 0", halted); n_bad++;
        end
        cyc(0, 0, 1, 32'h200);
        n_cmp++;
        if ({halted, cycle_count, halt_pc} !== {1'b1, 32'd5, 32'h200}) begin
            $display("FAIL gap_halt: got h%b cnt %0d pc %h want h1 cnt 5 pc 200",
                     halted, cycle_count, halt_pc);
            n_bad++;
        end
    endtask

    task automatic test_abort();
        run_up();
        for (int k = 1; k <= 7; k++) cyc(0, 0, 1, 32'h800 + 32'(4 * k));
        cyc(1, 1, 1, 32'h3010);
        n_cmp++;
        if ({core_rst_n, running, halted, cycle_count} !== {2'b00, 2'b00, 32'd7}) begin
            $display("FAIL abort: got rst %b r%b h%b cnt %0d want rst 00 r0 h0 cnt 7",
                     core_rst_n, running, halted, cycle_count);
            n_bad++;
        end
        repeat (3) cyc(0, 0, 1, 32'h900);
        n_cmp++;
        if ({core_rst_n, cycle_count} !== {2'b00, 32'd7}) begin
            $display("FAIL abort_idle: got rst %b cnt %0d want rst 00 cnt 7", core_rst_n, cycle_count);
            n_bad++;
        end
    endtask

    task automatic test_start_in_hold();
        cyc(1, 0, 0, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            cyc(k == 2, 0, 0, 32'h0);
            if (k == 4 || k == 6) begin
                n_cmp++;
                if ({core_rst_n, running} !== ((k == 4) ? 3'b010 : 3'b111)) begin
                    $display("FAIL start_in_hold_edge%0d: got rst %b r%b", k, core_rst_n, running);
                    n_bad++;
                end
            end
        end
    endtask

    task automatic test_restart();
        repeat (3) cyc(0, 0, 1, 32'h500);
        n_cmp++;
        if (halted !== 1'b1) begin
            $display("FAIL restart_pre: halted got %b want 1", halted); n_bad++;
        end
        cyc(1, 0, 0, 32'h0);
        n_cmp++;
        if ({core_rst_n, running, halted, cycle_count, halt_pc} !== {4'b0000, 32'd0, 32'd0}) begin
            $display("FAIL restart: got rst %b r%b h%b cnt %0d pc %h want all zero",
                     core_rst_n, running, halted, cycle_count, halt_pc);
            n_bad++;
        end
    endtask

    task automatic test_async_reset();
        repeat (RST_CYCLES + (NC - 1) * STAGGER) cyc(0, 0, 0, 32'h0);
        repeat (3) cyc(0, 0, 1, 32'hA00);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({core_rst_n, running} !== 3'b000) begin
            $display("FAIL async_reset: got rst %b r%b want rst 00 r0", core_rst_n, running); n_bad++;
        end
        n_cmp++;
        if (cycle_count !== 32'd0) begin
            $display("FAIL async_reset_cnt: got %0d want 0", cycle_count); n_bad++;
        end
        model_reset();
        #2 reset = 1'b1;
        repeat (3) cyc(0, 0, 1, 32'hA00);
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
            $display("FAIL post_reset_idle: got %h want %h", dut_vec(), mdl_vec()); n_bad++;
        end
    endtask

    task automatic test_random();
        bit st, ab, pv;
        logic [31:0] p;
        for (int k = 0; k < 400; k++) begin
            st = ($urandom_range(0, 5) == 0);
            ab = ($urandom_range(0, 40) == 0);
            pv = ($urandom_range(0, 3) != 0);
            p  = ($urandom_range(0, 15) == 0) ? HALT_ADDR : 32'h40 + 32'(4 * $urandom_range(0, 2));
            cyc(st, ab, pv, p);
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                $display("FAIL random_cycle%0d: got %h want %h", k, dut_vec(), mdl_vec()); n_bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stagger();
        test_halt_repeat();
        test_timeout();
        test_timeout_vs_halt();
        test_halt_pc();
        test_valid_gaps();
        test_abort();
        test_start_in_hold();
        test_restart();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: reached 200000 want earlier finish");
        $fatal(1);
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesizable run controller for the pipelined MIPS core(s). Replaces the bare free-running clock/reset stimulus with a sequencer that:
  - holds and releases per-core resets in a staggered, parametrised order;
  - counts execution cycles;
  - detects program completion (PC self-loop or fixed halt PC);
  - flags a watchdog timeout.
- Sits between the top-level clock/reset and one or more mips instances. Usable in the bench and on the board.

Parameters:
NUM_CORES, 1, number of core reset channels driven (1..8)
PC_W, 32, program counter width
CNT_W, 32, cycle counter width
RST_CYCLES, 4, cycles core 0 is held in reset after start (>=1)
STAGGER, 0, extra cycles between successive core reset releases
HALT_REPEAT, 3, consecutive valid cycles with unchanged PC that constitute a halt (>=2)
HALT_PC_EN, 0, 1 = also halt when pc == HALT_PC
HALT_PC, 32'h0000_3000, fixed halt address (used only if HALT_PC_EN)
MAX_CYCLES, 100000, watchdog limit in RUN cycles

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset for this block
start  in  1  single-cycle pulse: begin (or restart) a run
abort  in  1  force return to IDLE
pc_valid  in  1  pc is meaningful this cycle (core 0 fetch stage)
pc  in  PC_W  current PC of core 0
core_rst_n  out  NUM_CORES  per-core active-low reset, registered
running  out  1  high while in RUN
halted  out  1  sticky, program reached halt condition
timeout  out  1  sticky, watchdog expired
cycle_count  out  CNT_W  RUN cycles elapsed, saturating
halt_pc  out  PC_W  PC captured at halt

Behaviour:
- reset low (async), outputs:
  - state = IDLE;
  - core_rst_n = all 0; running = 0, halted = 0, timeout = 0;
  - cycle_count = 0, halt_pc = 0;
  - internal hold and repeat counters = 0.
- States: IDLE, HOLD, RUN, HALTED, TIMEOUT. All outputs registered.
- IDLE:
  - core_rst_n all 0.
  - start=1 → HOLD; clear hold_cnt, cycle_count, halted, timeout, halt_pc.
- HOLD:
  - hold_cnt increments each cycle.
  - core_rst_n[i] goes high at the edge where hold_cnt reaches RST_CYCLES + i*STAGGER; it stays high thereafter.
  - At the edge releasing core NUM_CORES-1 → RUN; running rises on that same edge.
  - start ignored.
- RUN:
  - cycle_count += 1 per cycle, saturating at all-ones.
  - Repeat tracking on pc_valid=1:
    - pc == last_pc → rep_cnt += 1;
    - otherwise rep_cnt = 1 and last_pc = pc.
  - pc_valid=0: last_pc and rep_cnt hold.
  - Halt condition:
    - pc_valid=1 and rep_cnt+1 >= HALT_REPEAT with pc == last_pc; or
    - HALT_PC_EN and pc_valid=1 and pc == HALT_PC.
  - Halt → HALTED: halted=1, halt_pc=pc, running=0.
  - Watchdog: cycle_count == MAX_CYCLES-1 with no halt that cycle → TIMEOUT: timeout=1, running=0.
  - Halt and watchdog in the same cycle: halt wins, timeout stays 0.
  - start ignored.
- HALTED / TIMEOUT:
  - core_rst_n stays all 1; flags sticky; cycle_count frozen.
  - start → HOLD (full restart: core_rst_n all 0 on that edge, flags cleared).
- abort=1 in any state:
  - next edge → IDLE; core_rst_n all 0; running 0.
  - halted, timeout, cycle_count retain their values until the next start.
  - abort has priority over start and over all RUN events.
- Reset asserted mid-run: immediate async clear to reset values; core_rst_n drops without waiting for clk.
- Widths: compare counters are zero-extended to CNT_W. hold_cnt is sized to hold RST_CYCLES + (NUM_CORES-1)*STAGGER.

Decomposition:
- Package mips_run_pkg:
  - state enum (IDLE, HOLD, RUN, HALTED, TIMEOUT);
  - localparam function computing hold_cnt width;
  - parameter sanity checks (HALT_REPEAT>=2, RST_CYCLES>=1, NUM_CORES 1..8).
- Sub-module mips_halt_detect:
  - owns last_pc and rep_cnt;
  - outputs a one-cycle halt_hit;
  - parameters PC_W, HALT_REPEAT, HALT_PC_EN, HALT_PC.
- Top module holds the FSM, the hold/cycle counters and the output registers.

Test Plan:
- NUM_CORES=2, RST_CYCLES=4, STAGGER=2; start at edge 0 → core_rst_n = 2'b00 until edge 4, 2'b01 at edge 4, 2'b11 and running=1 at edge 6.
- RUN, HALT_REPEAT=3; pc sequence 0x3000, 0x3004, 0x3008, 0x3008, 0x3008 (pc_valid=1 throughout) → halted=1 and halt_pc=0x3008 on the edge sampling the third 0x3008; running=0; cycle_count frozen at 5.
- MAX_CYCLES=10, pc incrementing by 4 every cycle → timeout=1 after 10 RUN cycles, cycle_count=10, halted=0. Variant with the halt condition in cycle 10 → halted=1, timeout=0.
- HALT_PC_EN=1, HALT_PC=0x3010; pc reaches 0x3010 once → halted=1, halt_pc=0x3010 on that edge. pc_valid=0 gaps inside a repeat run → rep_cnt holds and the halt is delayed accordingly.
- abort in RUN at cycle 7 → IDLE next edge, core_rst_n=0, cycle_count stays 7. start pulse during HOLD has no effect. start in HALTED → restart, halted clears, cycle_count=0.
- reset driven low mid-RUN between clock edges → core_rst_n=0 and running=0 immediately. After reset high, no activity until start.
